uart_frame_arbiter: RTL and testbench

Round-robin scheduler that shares the single `uart_tx` serializer among `N_REQ` sample producers. Each granted 16-bit sample is wrapped in a 5-byte frame: sync, header, data-hi, data-lo, XOR checksum. The frame is fed to `uart_tx` one byte at a time over its DV/ready/done handshake. It sits between the spike-sampler channels and `uart_tx` in the top level, replacing the button-driven `uart_tx_en` logic.

---
 rtl/uart_frame_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_frame_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_arbiter.sv
// Round-robin scheduler that frames 16-bit samples from N_REQ producers
// into 5-byte packets (sync, header, hi, lo, checksum) for a shared uart_tx.
module uart_frame_arbiter #(
  parameter int         N_REQ     = 2,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ack,
  output logic                 tx_dv,
  output logic [7:0]           tx_byte,
  input  logic                 tx_ready,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t      state, state_n;
  logic [2:0]  last;
  logic [2:0]  bidx;
  logic [3:0]  seq;
  logic [15:0] data_cap;
  logic        grant_vld;
  logic [2:0]  grant_idx;
  logic [7:0]  valid8;
  logic [15:0] data_arr [8];

  // Pad requesters out to 8 slots so a 3-bit grant index can select directly.
  for (genvar gi = 0; gi < 8; gi++) begin : g_slot
    if (gi < N_REQ) begin : g_used
      assign valid8[gi]   = req_valid[gi];
      assign data_arr[gi] = req_data[16*gi +: 16];
    end else begin : g_pad
      assign valid8[gi]   = 1'b0;
      assign data_arr[gi] = 16'h0000;
    end
  end

  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [3:0]  s,
                                            input logic [2:0]  g,
                                            input logic [15:0] d);
    logic [7:0] hdr;
    hdr = {s, 1'b0, g};
    case (idx)
      3'd0:    frame_byte = SYNC_BYTE;
      3'd1:    frame_byte = hdr;
      3'd2:    frame_byte = d[15:8];
      3'd3:    frame_byte = d[7:0];
      default: frame_byte = hdr ^ d[15:8] ^ d[7:0];
    endcase
  endfunction

  // Search starts just past the last winner so every active requester is served once per rotation.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!grant_vld && valid8[3'((int'(last) + i) % N_REQ)]) begin
        grant_vld = 1'b1;
        grant_idx = 3'((int'(last) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant_vld) state_n = SEND;
      SEND:    if (tx_ready)  state_n = WAIT;
      WAIT:    if (tx_done)   state_n = (bidx == 3'd4) ? IDLE : SEND;
      default: state_n = IDLE;
    endcase
  end

  // Control and registered outputs
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 3'(N_REQ - 1);
      seq        <= 4'd0;
      bidx       <= 3'd0;
      req_ack    <= '0;
      tx_dv      <= 1'b0;
      tx_byte    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      busy       <= (state_n != IDLE);
      tx_dv      <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < N_REQ; i++)
        req_ack[i] <= (state == IDLE) && grant_vld && (grant_idx == 3'(i));
      case (state)
        IDLE: if (grant_vld) begin
          last <= grant_idx;
          bidx <= 3'd0;
        end
        SEND: if (tx_ready) begin
          tx_dv   <= 1'b1;
          tx_byte <= frame_byte(bidx, seq, last, data_cap);
        end
        WAIT: if (tx_done) begin
          if (bidx == 3'd4) begin
            frame_done <= 1'b1;
            seq        <= seq + 4'd1;
          end else begin
            bidx <= bidx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sample capture; holds the granted data for the whole frame
  always_ff @(posedge sysclk) begin
    if (state == IDLE && grant_vld)
      data_cap <= data_arr[grant_idx];
  end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Bench for uart_frame_arbiter: a uart_tx responder model plus a byte
// scoreboard that compares each tx_dv strobe against queued frame bytes.
module tb_uart_frame_arbiter;

  localparam int N   = 2;
  localparam int LAT = 4;

  logic          sysclk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [16*N-1:0] req_data;
  logic [N-1:0]  req_ack;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          tx_ready;
  logic          tx_done;
  logic          busy;
  logic          frame_done;

  logic stall      = 1'b0;
  logic force_done = 1'b0;
  logic mdl_ready  = 1'b1;
  logic mdl_done   = 1'b0;
  int   mdl_cnt    = 0;

  int         checks   = 0;
  int         failures = 0;
  string      cur_test = "init";
  logic [7:0] exp_q[$];
  logic [N-1:0] ack_q[$];
  int         fd_cnt   = 0;
  int         byte_cnt = 0;
  int         dv_viol  = 0;
  logic       prev_dv  = 1'b0;
  logic [7:0] last_hdr = 8'hFF;
  logic [3:0] tb_seq   = 4'd0;

  uart_frame_arbiter #(.N_REQ(N), .SYNC_BYTE(8'hA5)) dut (
    .sysclk(sysclk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_ready(tx_ready),
    .tx_done(tx_done), .busy(busy), .frame_done(frame_done)
  );

  always #5 sysclk = ~sysclk;

  assign tx_ready = mdl_ready && !stall;
  assign tx_done  = mdl_done || force_done;

  // uart_tx stand-in: ready drops on a strobe, done pulses LAT cycles later
  always @(posedge sysclk) begin
    mdl_done <= 1'b0;
    if (tx_dv) begin
      mdl_ready <= 1'b0;
      mdl_cnt   <= LAT;
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        mdl_done  <= 1'b1;
        mdl_ready <= 1'b1;
      end
    end
  end

  // Scoreboard: every strobed byte must match the head of the expected queue
  always @(negedge sysclk) begin
    if (tx_dv) begin
      logic [7:0] e;
      checks++;
      byte_cnt++;
      if (byte_cnt % 5 == 2) last_hdr = tx_byte;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s unexpected byte got=%h (none expected)", cur_test, tx_byte);
      end else begin
        e = exp_q.pop_front();
        if (tx_byte !== e) begin
          failures++;
          $display("FAIL %s byte%0d got=%h exp=%h", cur_test, byte_cnt, tx_byte, e);
        end
      end
      if (prev_dv || !tx_ready) dv_viol++;
    end
    prev_dv = tx_dv;
    if (frame_done) fd_cnt++;
    if (|req_ack) ack_q.push_back(req_ack);
  end

  function automatic void push_frame(input logic [2:0] g, input logic [15:0] d);
    logic [7:0] hdr;
    hdr = {tb_seq, 1'b0, g};
    exp_q.push_back(8'hA5);
    exp_q.push_back(hdr);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(hdr ^ d[15:8] ^ d[7:0]);
    tb_seq = tb_seq + 4'd1;
  endfunction

  task automatic apply_reset();
    reset = 1'b1; req_valid = '0; req_data = '0; stall = 1'b0; force_done = 1'b0;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    reset = 1'b0;
    exp_q.delete(); ack_q.delete();
    fd_cnt = 0; byte_cnt = 0; tb_seq = 4'd0;
  endtask

  task automatic wait_ack(input int n);
    for (int i = 0; i < 300 && ack_q.size() < n; i++) @(negedge sysclk);
  endtask

  task automatic wait_fd(input int n);
    for (int i = 0; i < 3000 && fd_cnt < n; i++) @(negedge sysclk);
    repeat (2) @(negedge sysclk);
  endtask

  task automatic test_reset();
    cur_test = "reset";
    reset = 1'b1; req_valid = '0; req_data = '0;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    checks += 5;
    if (busy !== 1'b0)       begin failures++; $display("FAIL reset busy got=%b exp=0", busy); end
    if (tx_dv !== 1'b0)      begin failures++; $display("FAIL reset tx_dv got=%b exp=0", tx_dv); end
    if (tx_byte !== 8'h00)   begin failures++; $display("FAIL reset tx_byte got=%h exp=00", tx_byte); end
    if (req_ack !== 2'b00)   begin failures++; $display("FAIL reset req_ack got=%b exp=00", req_ack); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset frame_done got=%b exp=0", frame_done); end
    apply_reset();
  endtask

  task automatic test_single_frame();
    apply_reset();
    cur_test = "single";
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h12);
    exp_q.push_back(8'h34); exp_q.push_back(8'h26);
    req_data = {16'h0000, 16'h1234};
    req_valid = 2'b01;
    @(posedge sysclk);
    @(negedge sysclk);
    checks += 3;
    if (req_ack !== 2'b01) begin failures++; $display("FAIL single ack got=%b exp=01", req_ack); end
    if (busy !== 1'b1)     begin failures++; $display("FAIL single busy got=%b exp=1", busy); end
    if (tx_dv !== 1'b0)    begin failures++; $display("FAIL single early_dv got=%b exp=0", tx_dv); end
    req_valid = 2'b00;
    @(negedge sysclk);
    checks += 2;
    if (req_ack !== 2'b00) begin failures++; $display("FAIL single ack_width got=%b exp=00", req_ack); end
    if (tx_dv !== 1'b1)    begin failures++; $display("FAIL single first_dv got=%b exp=1", tx_dv); end
    wait_fd(1);
    checks += 4;
    if (fd_cnt !== 1)        begin failures++; $display("FAIL single frame_done got=%0d exp=1", fd_cnt); end
    if (exp_q.size() !== 0)  begin failures++; $display("FAIL single leftover got=%0d exp=0", exp_q.size()); end
    if (ack_q.size() !== 1)  begin failures++; $display("FAIL single ack_count got=%0d exp=1", ack_q.size()); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL single idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    cur_test = "simul";
    req_data = {16'hBEEF, 16'h1234};
    push_frame(3'd0, 16'h1234);
    push_frame(3'd1, 16'hBEEF);
    push_frame(3'd0, 16'h1234);
    req_valid = 2'b11;
    wait_ack(3);
    req_valid = 2'b00;
    wait_fd(3);
    checks += 3;
    if (fd_cnt !== 3)       begin failures++; $display("FAIL simul frames got=%0d exp=3", fd_cnt); end
    if (exp_q.size() !== 0) begin failures++; $display("FAIL simul leftover got=%0d exp=0", exp_q.size()); end
    if (ack_q.size() !== 3) begin failures++; $display("FAIL simul ack_count got=%0d exp=3", ack_q.size()); end
    else begin
      checks++;
      if (ack_q[0] !== 2'b01 || ack_q[1] !== 2'b10 || ack_q[2] !== 2'b01) begin
        failures++;
        $display("FAIL simul order got=%b,%b,%b exp=01,10,01", ack_q[0], ack_q[1], ack_q[2]);
      end
    end
  endtask

  task automatic test_ready_stall();
    int bad_dv, bad_byte, bad_busy, dv_seen;
    apply_reset();
    cur_test = "stall";
    bad_dv = 0; bad_byte = 0; bad_busy = 0; dv_seen = 0;
    stall = 1'b1;
    req_data = {16'h0000, 16'hC3F0};
    push_frame(3'd0, 16'hC3F0);
    req_valid = 2'b01;
    wait_ack(1);
    req_valid = 2'b00;
    repeat (50) begin
      @(negedge sysclk);
      if (tx_dv !== 1'b0)    bad_dv++;
      if (tx_byte !== 8'h00) bad_byte++;
      if (busy !== 1'b1)     bad_busy++;
    end
    checks += 3;
    if (bad_dv != 0)   begin failures++; $display("FAIL stall dv got=%0d cycles high exp=0", bad_dv); end
    if (bad_byte != 0) begin failures++; $display("FAIL stall byte got=%0d cycles changed exp=0", bad_byte); end
    if (bad_busy != 0) begin failures++; $display("FAIL stall busy got=%0d cycles low exp=0", bad_busy); end
    stall = 1'b0;
    repeat (3) begin
      @(negedge sysclk);
      if (tx_dv) dv_seen++;
    end
    checks++;
    if (dv_seen != 1) begin failures++; $display("FAIL stall release got=%0d strobes exp=1", dv_seen); end
    wait_fd(1);
    checks += 2;
    if (fd_cnt !== 1)       begin failures++; $display("FAIL stall frames got=%0d exp=1", fd_cnt); end
    if (exp_q.size() !== 0) begin failures++; $display("FAIL stall leftover got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_seq_wrap();
    apply_reset();
    cur_test = "wrap";
    for (int i = 0; i < 17; i++) begin
      logic [7:0] b;
      b = 8'(i * 37 + 5);
      req_data = {16'h0000, b, ~b};
      push_frame(3'd0, {b, ~b});
      req_valid = 2'b01;
      wait_ack(i + 1);
      req_valid = 2'b00;
      wait_fd(i + 1);
    end
    checks += 3;
    if (fd_cnt !== 17)        begin failures++; $display("FAIL wrap frames got=%0d exp=17", fd_cnt); end
    if (exp_q.size() !== 0)   begin failures++; $display("FAIL wrap leftover got=%0d exp=0", exp_q.size()); end
    if (last_hdr !== 8'h00)   begin failures++; $display("FAIL wrap hdr17 got=%h exp=00", last_hdr); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    cur_test = "midreset";
    req_data = {16'h0000, 16'h7788};
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h77);
    req_valid = 2'b01;
    wait_ack(1);
    req_valid = 2'b00;
    for (int i = 0; i < 300 && byte_cnt < 3; i++) @(negedge sysclk);
    reset = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    checks += 3;
    if (busy !== 1'b0)      begin failures++; $display("FAIL midreset busy got=%b exp=0", busy); end
    if (tx_dv !== 1'b0)     begin failures++; $display("FAIL midreset dv got=%b exp=0", tx_dv); end
    if (exp_q.size() !== 0) begin failures++; $display("FAIL midreset sent got=%0d left exp=0", exp_q.size()); end
    reset = 1'b0;
    ack_q.delete(); fd_cnt = 0; byte_cnt = 0; tb_seq = 4'd0;
    req_data = {16'h2222, 16'h1111};
    push_frame(3'd0, 16'h1111);
    req_valid = 2'b11;
    wait_ack(1);
    req_valid = 2'b00;
    wait_fd(1);
    checks += 3;
    if (ack_q.size() < 1 || ack_q[0] !== 2'b01) begin failures++; $display("FAIL midreset tie got=%0d acks exp=first 01", ack_q.size()); end
    if (fd_cnt !== 1)       begin failures++; $display("FAIL midreset frames got=%0d exp=1", fd_cnt); end
    if (exp_q.size() !== 0) begin failures++; $display("FAIL midreset leftover got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_spurious_done();
    apply_reset();
    cur_test = "spurious";
    force_done = 1'b1;
    @(negedge sysclk);
    force_done = 1'b0;
    repeat (2) @(negedge sysclk);
    checks += 2;
    if (busy !== 1'b0)  begin failures++; $display("FAIL spurious idle_busy got=%b exp=0", busy); end
    if (byte_cnt !== 0) begin failures++; $display("FAIL spurious idle_bytes got=%0d exp=0", byte_cnt); end
    stall = 1'b1;
    req_data = {16'h0000, 16'h9A5C};
    push_frame(3'd0, 16'h9A5C);
    req_valid = 2'b01;
    wait_ack(1);
    req_valid = 2'b00;
    @(negedge sysclk);
    force_done = 1'b1;
    @(negedge sysclk);
    force_done = 1'b0;
    repeat (3) @(negedge sysclk);
    checks += 2;
    if (busy !== 1'b1)  begin failures++; $display("FAIL spurious send_busy got=%b exp=1", busy); end
    if (byte_cnt !== 0) begin failures++; $display("FAIL spurious send_bytes got=%0d exp=0", byte_cnt); end
    stall = 1'b0;
    wait_fd(1);
    checks += 2;
    if (fd_cnt !== 1)       begin failures++; $display("FAIL spurious frames got=%0d exp=1", fd_cnt); end
    if (exp_q.size() !== 0) begin failures++; $display("FAIL spurious leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0;
    test_reset();
    test_single_frame();
    test_simultaneous();
    test_ready_stall();
    test_seq_wrap();
    test_reset_mid_frame();
    test_spurious_done();
    checks++;
    if (dv_viol !== 0) begin failures++; $display("FAIL strobe_rules got=%0d violations exp=0", dv_viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
